// File: rtl/signed_balance_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : signed_balance_accum
// Brief   : Vending balance accumulator with credit limit and chunked refunds.
// Revision: 1.0 - initial release
// ============================================================================
module signed_balance_accum #(
    parameter int CREDIT_LIMIT = 4,
    parameter int REFUND_CHUNK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    input  logic       buy_req,
    input  logic [3:0] price,
    input  logic       refund_req,
    input  logic       refund_ready,
    output logic [4:0] balance,
    output logic       is_negative,
    output logic       busy,
    output logic       dispense,
    output logic       deny,
    output logic       coin_reject,
    output logic       refund_err,
    output logic       refund_valid,
    output logic [3:0] refund_amt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VEND   = 2'd1;
    localparam logic [1:0] S_REFUND = 2'd2;

    // Limits are clamped to what the 5-bit balance and 4-bit chunk can carry.
    localparam int c_credit_eff = (CREDIT_LIMIT > 16) ? 16 : ((CREDIT_LIMIT < 0) ? 0 : CREDIT_LIMIT);
    localparam int c_chunk_eff  = (REFUND_CHUNK > 15) ? 15 : ((REFUND_CHUNK < 1) ? 1 : REFUND_CHUNK);
    localparam logic signed [5:0] c_min_balance = 6'sd0 - $signed(6'(c_credit_eff));
    localparam logic signed [5:0] c_max_balance = 6'sd15;
    localparam logic [3:0]        c_chunk       = 4'(c_chunk_eff);

    logic [1:0]        r_state;
    logic signed [4:0] r_balance;
    logic              r_dispense;
    logic              r_deny;
    logic              r_coin_reject;
    logic              r_refund_err;
    logic              r_refund_valid;
    logic [3:0]        r_refund_amt;

    logic [1:0]        w_state_next;
    logic signed [4:0] w_balance_next;
    logic              w_dispense_next;
    logic              w_deny_next;
    logic              w_coin_reject_next;
    logic              w_refund_err_next;
    logic              w_refund_valid_next;
    logic [3:0]        w_refund_amt_next;

    logic signed [5:0] w_bal_ext;
    logic signed [5:0] w_coin_sum;
    logic signed [5:0] w_buy_diff;
    logic signed [5:0] w_refund_left;
    logic              w_coin_ok;
    logic              w_buy_ok;
    logic              w_bal_positive;
    logic [3:0]        w_entry_amt;
    logic [3:0]        w_left_amt;

    assign w_bal_ext      = {r_balance[4], r_balance};
    assign w_coin_sum     = w_bal_ext + $signed({2'b00, coin_value});
    assign w_buy_diff     = w_bal_ext - $signed({2'b00, price});
    assign w_refund_left  = w_bal_ext - $signed({2'b00, r_refund_amt});
    assign w_coin_ok      = (w_coin_sum <= c_max_balance);
    assign w_buy_ok       = (w_buy_diff >= c_min_balance);
    assign w_bal_positive = !r_balance[4] && (r_balance != 5'sd0);

    // Only meaningful while the respective balance is positive (0..15).
    assign w_entry_amt = (r_balance[3:0] > c_chunk) ? c_chunk : r_balance[3:0];
    assign w_left_amt  = (w_refund_left[3:0] > c_chunk) ? c_chunk : w_refund_left[3:0];

    always_comb begin
        w_state_next        = r_state;
        w_balance_next      = r_balance;
        w_dispense_next     = 1'b0;
        w_deny_next         = 1'b0;
        w_coin_reject_next  = 1'b0;
        w_refund_err_next   = 1'b0;
        w_refund_valid_next = r_refund_valid;
        w_refund_amt_next   = r_refund_amt;
        case (r_state)
            S_IDLE: begin
                if (coin_valid) begin
                    if (w_coin_ok) w_balance_next = w_coin_sum[4:0];
                    else           w_coin_reject_next = 1'b1;
                end else if (buy_req) begin
                    if (w_buy_ok) begin
                        w_balance_next  = w_buy_diff[4:0];
                        w_state_next    = S_VEND;
                        w_dispense_next = 1'b1;
                    end else begin
                        w_deny_next = 1'b1;
                    end
                end else if (refund_req) begin
                    if (w_bal_positive) begin
                        w_state_next        = S_REFUND;
                        w_refund_valid_next = 1'b1;
                        w_refund_amt_next   = w_entry_amt;
                    end else begin
                        w_refund_err_next = 1'b1;
                    end
                end
            end
            S_VEND: begin
                w_state_next = S_IDLE;
            end
            S_REFUND: begin
                if (refund_ready) begin
                    w_balance_next = w_refund_left[4:0];
                    if (w_refund_left == 6'sd0) begin
                        w_state_next        = S_IDLE;
                        w_refund_valid_next = 1'b0;
                        w_refund_amt_next   = 4'd0;
                    end else begin
                        w_refund_amt_next = w_left_amt;
                    end
                end
            end
            default: begin
                w_state_next        = S_IDLE;
                w_refund_valid_next = 1'b0;
                w_refund_amt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_balance      <= 5'sd0;
            r_dispense     <= 1'b0;
            r_deny         <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_refund_err   <= 1'b0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= 4'd0;
        end else begin
            r_state        <= w_state_next;
            r_balance      <= w_balance_next;
            r_dispense     <= w_dispense_next;
            r_deny         <= w_deny_next;
            r_coin_reject  <= w_coin_reject_next;
            r_refund_err   <= w_refund_err_next;
            r_refund_valid <= w_refund_valid_next;
            r_refund_amt   <= w_refund_amt_next;
        end
    end

    assign balance      = r_balance;
    assign is_negative  = r_balance[4];
    assign busy         = (r_state != S_IDLE);
    assign dispense     = r_dispense;
    assign deny         = r_deny;
    assign coin_reject  = r_coin_reject;
    assign refund_err   = r_refund_err;
    assign refund_valid = r_refund_valid;
    assign refund_amt   = r_refund_amt;

endmodule
`default_nettype wire

// File: tb/tb_signed_balance_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_signed_balance_accum
// Brief   : Directed scoreboard bench for signed_balance_accum.
// Revision: 1.0 - initial release
// ============================================================================
module tb_signed_balance_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = 4'd0;
    logic       buy_req = 1'b0;
    logic [3:0] price = 4'd0;
    logic       refund_req = 1'b0;
    logic       refund_ready = 1'b0;
    logic [4:0] balance;
    logic       is_negative;
    logic       busy;
    logic       dispense;
    logic       deny;
    logic       coin_reject;
    logic       refund_err;
    logic       refund_valid;
    logic [3:0] refund_amt;

    always #5 clk = ~clk;

    signed_balance_accum #(.CREDIT_LIMIT(4), .REFUND_CHUNK(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .buy_req      (buy_req),
        .price        (price),
        .refund_req   (refund_req),
        .refund_ready (refund_ready),
        .balance      (balance),
        .is_negative  (is_negative),
        .busy         (busy),
        .dispense     (dispense),
        .deny         (deny),
        .coin_reject  (coin_reject),
        .refund_err   (refund_err),
        .refund_valid (refund_valid),
        .refund_amt   (refund_amt)
    );

    // flags = {busy, dispense, deny, coin_reject, refund_err, refund_valid}
    typedef struct packed {
        logic [4:0] bal;
        logic [5:0] flags;
        logic [3:0] amt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic exp_t mk(input logic [4:0] b, input logic [5:0] f, input logic [3:0] a);
        exp_t e;
        e.bal   = b;
        e.flags = f;
        e.amt   = a;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL step %0d %s observed=%0h expected=%0h", step_no, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        e = sb_q.pop_front();
        cmp("balance",      {3'b000, balance},     {3'b000, e.bal});
        cmp("is_negative",  {7'd0, is_negative},   {7'd0, e.bal[4]});
        cmp("busy",         {7'd0, busy},          {7'd0, e.flags[5]});
        cmp("dispense",     {7'd0, dispense},      {7'd0, e.flags[4]});
        cmp("deny",         {7'd0, deny},          {7'd0, e.flags[3]});
        cmp("coin_reject",  {7'd0, coin_reject},   {7'd0, e.flags[2]});
        cmp("refund_err",   {7'd0, refund_err},    {7'd0, e.flags[1]});
        cmp("refund_valid", {7'd0, refund_valid},  {7'd0, e.flags[0]});
        cmp("refund_amt",   {4'd0, refund_amt},    {4'd0, e.amt});
    endtask

    task automatic step(input logic cv, input logic [3:0] cval, input logic br, input logic [3:0] pr,
                        input logic rr, input logic rdy, input logic rn, input exp_t e);
        @(negedge clk);
        coin_valid   = cv;
        coin_value   = cval;
        buy_req      = br;
        price        = pr;
        refund_req   = rr;
        refund_ready = rdy;
        rst_n        = rn;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        check_outputs();
    endtask

    initial begin
        // reset
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, mk(5'd0,  6'b000000, 4'd0));
        // coin 5
        step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd5,  6'b000000, 4'd0));
        // buy 7 -> -2, vend cycle
        step(1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, mk(5'h1E, 6'b110000, 4'd0));
        // coin during VEND is ignored
        step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'h1E, 6'b000000, 4'd0));
        // buy 3 at -2 exceeds credit
        step(1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, mk(5'h1E, 6'b001000, 4'd0));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'h1E, 6'b000000, 4'd0));
        // refund with negative balance
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(5'h1E, 6'b000010, 4'd0));
        // coin while in debt: -2 + 15 = 13
        step(1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd13, 6'b000000, 4'd0));
        step(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd14, 6'b000000, 4'd0));
        // 14 + 3 overflows
        step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd14, 6'b000100, 4'd0));
        // coin wins over buy and refund; lands exactly on 15
        step(1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, mk(5'd15, 6'b000000, 4'd0));
        step(1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, mk(5'd0, 6'b110000, 4'd0));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd0,  6'b000000, 4'd0));
        // buy to exactly -CREDIT_LIMIT
        step(1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, mk(5'h1C, 6'b110000, 4'd0));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'h1C, 6'b000000, 4'd0));
        step(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, mk(5'h1C, 6'b001000, 4'd0));
        step(1'b1, 4'd14, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd10, 6'b000000, 4'd0));
        // refund from 10 with back-pressure
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(5'd10, 6'b100001, 4'd4));
        step(1'b1, 4'd1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, mk(5'd10, 6'b100001, 4'd4));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, mk(5'd6,  6'b100001, 4'd4));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, mk(5'd2,  6'b100001, 4'd2));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd2,  6'b100001, 4'd2));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, mk(5'd0,  6'b000000, 4'd0));
        // refund at zero balance
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(5'd0,  6'b000010, 4'd0));
        step(1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd6,  6'b000000, 4'd0));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(5'd6,  6'b100001, 4'd4));
        // reset mid-refund aborts without payout
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, mk(5'd0,  6'b000000, 4'd0));
        step(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd2,  6'b000000, 4'd0));
        // buy wins over refund
        step(1'b0, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, mk(5'd1,  6'b110000, 4'd0));
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(5'd1,  6'b000000, 4'd0));

        cmp("scoreboard_empty", 8'(sb_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/signed_balance_accum.md
SIGNED_BALANCE_ACCUM -- requirements
Module: signed_balance_accum

Interface
REQ-001 SHALL have parameter CREDIT_LIMIT, default 4, meaning the maximum debt (magnitude) a purchase may leave.
REQ-002 SHALL have parameter REFUND_CHUNK, default 4, meaning the maximum refund paid per handshake.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 coin_valid  input  1  coin inserted this cycle.
REQ-006 coin_value  input  4  unsigned coin value, 0..15.
REQ-007 buy_req  input  1  purchase request this cycle.
REQ-008 price  input  4  unsigned item price, 0..15.
REQ-009 refund_req  input  1  request payout of positive balance.
REQ-010 refund_ready  input  1  downstream payout accepts current chunk.
REQ-011 balance  output  5  signed two's-complement balance, -16..15; feeds the downstream negation stage.
REQ-012 is_negative  output  1  equals balance[4].
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 dispense  output  1  one-cycle pulse, item released.
REQ-015 deny  output  1  one-cycle pulse, purchase refused.
REQ-016 coin_reject  output  1  one-cycle pulse, coin refused (would overflow).
REQ-017 refund_err  output  1  one-cycle pulse, refund refused (balance <= 0).
REQ-018 refund_valid  output  1  refund chunk offered.
REQ-019 refund_amt  output  4  unsigned chunk value while refund_valid.

Function
REQ-020 SHALL implement FSM states IDLE, VEND, REFUND.
REQ-021 In IDLE, only one event SHALL be accepted per cycle, with priority coin_valid > buy_req > refund_req; lower-priority requests in the same cycle are dropped, not queued.
REQ-022 Requests arriving in VEND or REFUND SHALL be ignored, with no pulse generated.
REQ-023 Coin: if balance + coin_value <= 15 (signed), balance SHALL update at the accepting edge (visible next cycle); otherwise balance is unchanged and coin_reject pulses next cycle.
REQ-024 Coin SHALL be accepted when balance is negative, reducing the debt.
REQ-025 Buy: if balance - price >= -CREDIT_LIMIT, balance SHALL be debited at the accepting edge, the FSM enters VEND for exactly one cycle with dispense=1, then returns to IDLE.
REQ-026 Buy failing REQ-025 SHALL leave balance unchanged, pulse deny next cycle, and stay in IDLE.
REQ-027 Refund: refund_req with balance > 0 SHALL enter REFUND; otherwise refund_err pulses next cycle and the FSM stays in IDLE.
REQ-028 In REFUND, refund_valid SHALL be 1 and refund_amt = min(balance, REFUND_CHUNK); both held stable until refund_ready.
REQ-029 On an edge with refund_valid && refund_ready, balance SHALL decrease by refund_amt; if the result is 0, the FSM returns to IDLE (refund_valid low next cycle).
REQ-030 All arithmetic SHALL use at least 6-bit signed intermediates; balance never wraps.
REQ-031 All pulse outputs SHALL be registered and last exactly one cycle.

Reset
REQ-032 While rst_n=0 at a rising edge: balance=0, state IDLE, busy, dispense, deny, coin_reject, refund_err, refund_valid = 0, refund_amt=0.
REQ-033 Reset SHALL override all events in the same cycle, including mid-VEND and mid-REFUND; any in-progress refund is aborted without payout.
REQ-034 No output SHALL change asynchronously to clk.

Verification
REQ-035 Reset, then coin 5 -> next cycle balance=5, is_negative=0, no pulses.
REQ-036 balance=5, buy price 7 -> balance=5'b11110 (-2), is_negative=1, dispense=1 for one cycle, busy=1 that cycle.
REQ-037 balance=-2, buy price 3 (-5 < -4) -> deny pulse, balance stays -2, no dispense.
REQ-038 balance=14, coin 3 -> coin_reject pulse, balance stays 14; coin and buy in the same cycle -> coin accepted, buy dropped.
REQ-039 balance=10, refund_req, refund_ready low 2 cycles then high -> refund_amt sequence 4 (held), 4, 2; then IDLE, balance=0; refund_req at balance 0 -> refund_err.
REQ-040 rst_n low during REFUND at balance 6 -> next cycle balance=0, refund_valid=0, busy=0.
